// File: rtl/mips_muldiv_pkg.sv
// Shared definitions for the iterative HI/LO multiply/divide unit: op codes,
// FSM states and the iteration counter width.
package mips_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'b000,
    OP_MULTU = 3'b001,
    OP_DIV   = 3'b010,
    OP_DIVU  = 3'b011,
    OP_MTHI  = 3'b100,
    OP_MTLO  = 3'b101
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

  function automatic int cnt_w(input int width);
    return $clog2(width);
  endfunction

endpackage

// File: rtl/mips_muldiv_step.sv
// One combinational iteration: shift-add multiply step, or (with
// MIPS_MULDIV_DIV_EN) one restoring subtract-shift divide step.
module mips_muldiv_step #(
  parameter int WIDTH = 32
) (
`ifdef MIPS_MULDIV_DIV_EN
  input  logic             i_div,
`endif
  input  logic [WIDTH-1:0] i_acc,
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_opnd,
  output logic [WIDTH-1:0] o_acc,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH:0] w_sum;

  // Multiplier bits retire out of i_q LSB-first while product bits shift in at the top.
  assign w_sum = {1'b0, i_acc} + (i_q[0] ? {1'b0, i_opnd} : '0);

`ifdef MIPS_MULDIV_DIV_EN
  logic [WIDTH:0] w_sh;
  logic [WIDTH:0] w_diff;

  assign w_sh   = {i_acc, i_q[WIDTH-1]};
  assign w_diff = w_sh - {1'b0, i_opnd};

  always_comb begin
    o_acc = w_sum[WIDTH:1];
    o_q   = {w_sum[0], i_q[WIDTH-1:1]};
    if (i_div) begin
      if (!w_diff[WIDTH]) begin
        o_acc = w_diff[WIDTH-1:0];
        o_q   = {i_q[WIDTH-2:0], 1'b1};
      end else begin
        o_acc = w_sh[WIDTH-1:0];
        o_q   = {i_q[WIDTH-2:0], 1'b0};
      end
    end
  end
`else
  assign o_acc = w_sum[WIDTH:1];
  assign o_q   = {w_sum[0], i_q[WIDTH-1:1]};
`endif

endmodule

// File: rtl/mips_muldiv.sv
// MIPS HI/LO multiply/divide unit, one bit per cycle on unsigned magnitudes.
// DIV/DIVU are only present when MIPS_MULDIV_DIV_EN is defined.
module mips_muldiv
  import mips_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = cnt_w(WIDTH);

  state_e           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_acc, r_q, r_opnd, r_hi, r_lo;
  logic [WIDTH-1:0] w_acc_nxt, w_q_nxt, w_abs_a, w_abs_b, w_hi_res, w_lo_res;
  logic [2*WIDTH-1:0] w_prod, w_prod_fix;
  logic             r_neg, r_done;
  logic             w_iter, w_signed, w_sa, w_sb, w_start;

`ifdef MIPS_MULDIV_DIV_EN
  logic r_div, r_neg_r, r_dz, w_is_div;
  assign w_is_div = (op == OP_DIV) || (op == OP_DIVU);
  assign w_iter   = (op == OP_MULT) || (op == OP_MULTU) || w_is_div;
`else
  assign w_iter   = (op == OP_MULT) || (op == OP_MULTU);
`endif

  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_sa     = w_signed & a[WIDTH-1];
  assign w_sb     = w_signed & b[WIDTH-1];
  assign w_abs_a  = w_sa ? -a : a;
  assign w_abs_b  = w_sb ? -b : b;
  assign w_start  = (r_state == ST_IDLE) && start && w_iter;

  assign busy = (r_state != ST_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

  mips_muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MIPS_MULDIV_DIV_EN
    .i_div  (r_div),
`endif
    .i_acc  (r_acc),
    .i_q    (r_q),
    .i_opnd (r_opnd),
    .o_acc  (w_acc_nxt),
    .o_q    (w_q_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_CALC;
      ST_CALC: if (r_cnt == '0) w_state_nxt = ST_FIN;
      ST_FIN:  w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Sign correction on the magnitude result; divide-by-zero forces LO to all ones.
  always_comb begin
    w_prod     = {r_acc, r_q};
    w_prod_fix = r_neg ? -w_prod : w_prod;
    w_hi_res   = w_prod_fix[2*WIDTH-1:WIDTH];
    w_lo_res   = w_prod_fix[WIDTH-1:0];
`ifdef MIPS_MULDIV_DIV_EN
    if (r_div) begin
      w_hi_res = r_neg_r ? -r_acc : r_acc;
      w_lo_res = r_dz ? '1 : (r_neg ? -r_q : r_q);
    end
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt  <= '0;
      r_acc  <= '0;
      r_q    <= '0;
      r_opnd <= '0;
      r_hi   <= '0;
      r_lo   <= '0;
      r_neg  <= 1'b0;
      r_done <= 1'b0;
`ifdef MIPS_MULDIV_DIV_EN
      r_div   <= 1'b0;
      r_neg_r <= 1'b0;
      r_dz    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_cnt  <= CW'(WIDTH - 1);
            r_acc  <= '0;
            r_q    <= w_abs_a;
            r_opnd <= w_abs_b;
            r_neg  <= w_sa ^ w_sb;
`ifdef MIPS_MULDIV_DIV_EN
            r_div   <= w_is_div;
            r_neg_r <= w_sa;
            r_dz    <= (b == '0);
`endif
          end else if (start && op == OP_MTHI) begin
            r_hi <= a;
          end else if (start && op == OP_MTLO) begin
            r_lo <= a;
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_nxt;
          r_q   <= w_q_nxt;
          if (r_cnt != '0) r_cnt <= r_cnt - CW'(1);
        end
        ST_FIN: begin
          r_hi   <= w_hi_res;
          r_lo   <= w_lo_res;
          r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_muldiv.sv
// Scoreboard bench for mips_muldiv (WIDTH=32): expected HI/LO and issue cycle
// are queued at issue and checked by a monitor whenever done pulses.
module tb_mips_muldiv;

  localparam int W   = 32;
  localparam int LAT = W + 2;  // edges from start edge (counted as 1) to done

  logic          clk, reset, start;
  logic [2:0]    op;
  logic [W-1:0]  a, b;
  logic          busy, done;
  logic [W-1:0]  hi, lo;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           issue;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   total = 0;
  int   passed = 0;

  mips_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (done) begin
      exp_t e;
      if (sb.size() == 0) begin
        total++;
        $display("FAIL unexpected_done: done=1 with nothing outstanding at cycle %0d", cyc);
      end else begin
        e = sb.pop_front();
        total++;
        if ({hi, lo} !== {e.hi, e.lo})
          $display("FAIL result: got hi=%h lo=%h, want hi=%h lo=%h", hi, lo, e.hi, e.lo);
        else passed++;
        total++;
        if (cyc - e.issue !== LAT)
          $display("FAIL latency: got %0d edges, want %0d", cyc - e.issue, LAT);
        else passed++;
      end
    end
  end

  function automatic logic [2*W-1:0] model(input logic [2:0] o, input logic [W-1:0] x, y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    case (o)
      3'b000: begin q = sx * sy; p = q; return p; end
      3'b001: return {32'd0, x} * {32'd0, y};
      3'b010: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        p = {r[31:0], q[31:0]};
        return p;
      end
      3'b011: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
      default: return '0;
    endcase
  endfunction

  // Called at a negedge; the following posedge is the start edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] x, y, input logic push);
    exp_t e;
    logic [2*W-1:0] m;
    start = 1'b1; op = o; a = x; b = y;
    if (push) begin
      m = model(o, x, y);
      e.hi = m[2*W-1:W]; e.lo = m[W-1:0]; e.issue = cyc;
      sb.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (done) break;
    end
    if (n == 100) begin
      total++;
      $display("FAIL timeout: done=0 after %0d cycles, want done=1", n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; op = 3'b000; a = '0; b = '0;
    #1 reset = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passed++;
    total++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else passed++;
    total++; if (hi !== '0) $display("FAIL reset_hi: got %h want 0", hi); else passed++;
    total++; if (lo !== '0) $display("FAIL reset_lo: got %h want 0", lo); else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done();
    @(negedge clk);
    issue(3'b000, 32'hFFFF_FFFD, 32'd7, 1'b1);
    wait_done();
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      issue((i % 2 == 0) ? 3'b000 : 3'b001, $urandom, $urandom, 1'b1);
      wait_done();
    end
  endtask

`ifdef MIPS_MULDIV_DIV_EN
  task automatic test_div();
    logic [W-1:0] x, y;
    @(negedge clk);
    issue(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b1);
    wait_done();
    @(negedge clk);
    issue(3'b011, 32'd100, 32'd0, 1'b1);
    wait_done();
    @(negedge clk);
    issue(3'b010, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done();
    @(negedge clk);
    issue(3'b010, 32'hFFFF_FFF9, 32'd0, 1'b1);
    wait_done();
    for (int i = 0; i < 6; i++) begin
      x = $urandom;
      y = (i < 3) ? ($urandom & 32'h0000_FFFF) : $urandom;
      @(negedge clk);
      issue((i % 2 == 0) ? 3'b010 : 3'b011, x, y, 1'b1);
      wait_done();
    end
  endtask
`else
  task automatic test_div_disabled();
    logic [W-1:0] h0, l0;
    @(negedge clk);
    h0 = hi; l0 = lo;
    issue(3'b010, 32'hFFFF_FFF9, 32'd2, 1'b0);
    total++; if (busy !== 1'b0) $display("FAIL div_disabled_busy: got %b want 0", busy); else passed++;
    issue(3'b011, 32'd100, 32'd5, 1'b0);
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0) $display("FAIL divu_disabled_busy: got %b want 0", busy); else passed++;
    total++; if ({hi, lo} !== {h0, l0})
      $display("FAIL div_disabled_hilo: got %h_%h want %h_%h", hi, lo, h0, l0);
    else passed++;
  endtask
`endif

  task automatic test_back_to_back();
    @(negedge clk);
    issue(3'b001, 32'd5, 32'd7, 1'b1);
    repeat (3) @(negedge clk);
    issue(3'b001, 32'd2, 32'd3, 1'b0);
    total++; if (busy !== 1'b1) $display("FAIL busy_hold: got %b want 1", busy); else passed++;
    wait_done();
    issue(3'b001, 32'd2, 32'd3, 1'b1);
    total++; if (busy !== 1'b1) $display("FAIL b2b_busy: got %b want 1", busy); else passed++;
    wait_done();
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int dones;
    issue(3'b001, 32'd9, 32'd9, 1'b1);
    repeat (9) @(negedge clk);
    reset = 1'b0;
    #1;
    sb.delete();
    total++; if (busy !== 1'b0) $display("FAIL midreset_busy: got %b want 0", busy); else passed++;
    total++; if ({hi, lo} !== '0) $display("FAIL midreset_hilo: got %h_%h want 0", hi, lo); else passed++;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dones++;
    end
    total++; if (dones !== 0) $display("FAIL midreset_done: got %0d pulses want 0", dones); else passed++;
  endtask

  task automatic test_move();
    @(negedge clk);
    issue(3'b101, 32'h0000_1234, 32'd0, 1'b0);
    total++; if (lo !== 32'h0000_1234) $display("FAIL mtlo: got %h want 00001234", lo); else passed++;
    total++; if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL mtlo_ctrl: got busy=%b done=%b want 0 0", busy, done);
    else passed++;
    issue(3'b100, 32'hCAFE_0001, 32'd0, 1'b0);
    total++; if ({hi, lo} !== {32'hCAFE_0001, 32'h0000_1234})
      $display("FAIL mthi: got %h_%h want cafe0001_00001234", hi, lo);
    else passed++;
    issue(3'b110, 32'hDEAD_BEEF, 32'd1, 1'b0);
    @(negedge clk);
    total++; if ({busy, hi, lo} !== {1'b0, 32'hCAFE_0001, 32'h0000_1234})
      $display("FAIL reserved_op: got busy=%b hi=%h lo=%h want 0 cafe0001 00001234", busy, hi, lo);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_mult();
`ifdef MIPS_MULDIV_DIV_EN
    test_div();
`else
    test_div_disabled();
`endif
    test_back_to_back();
    test_reset_mid();
    test_move();
    repeat (3) @(negedge clk);
    total++; if (sb.size() !== 0) $display("FAIL drain: got %0d outstanding want 0", sb.size()); else passed++;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
